game_master_fsm_param: RTL and testbench
========================================

Name: game_master_fsm_param

Overview:
Parametrised game-master controller for the sprite shooting game. It supports N targets and M projectiles, a configurable win score, and a life counter. It sequences rounds and drives per-sprite write/enable strobes as bit vectors, and it reports win or loss to the end-of-game timer and display logic. It sits between the sprite instances (position/velocity registers, within-screen flags) and the collision detectors.

Parameters:
N_TARGETS, 3, number of target sprites (1..8)
N_SHOTS, 2, number of player projectiles fired together per launch (1..4)
SCORE_W, 4, score counter width
WIN_SCORE, 10, score that wins the game; must be ≤ 2^SCORE_W-1
LIVES, 3, lives at game start (≥1)
LIVES_W, 2, lives counter width; LIVES ≤ 2^LIVES_W-1

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low (rst==0 at posedge clk resets)
launch_key  in  1  fire request, level
target_within_screen  in  N_TARGETS  per-target on-screen flag
shot_within_screen  in  N_SHOTS  per-projectile on-screen flag
shot_hit  in  N_TARGETS  bit i = some projectile overlaps target i
ship_collision  in  1  a target touched the player ship
end_of_game_timer_running  in  1  end-of-game display timer busy
target_write_xy  out  N_TARGETS  load initial position
target_write_dxy  out  N_TARGETS  load velocity
target_enable_update  out  N_TARGETS  advance motion
shot_write_xy  out  N_SHOTS  load initial position
shot_write_dxy  out  N_SHOTS  load velocity
shot_enable_update  out  N_SHOTS  advance motion
end_of_game_timer_start  out  1  one-cycle start pulse
game_won  out  1  sticky until next START_GAME
game_lost  out  1  sticky until next START_GAME
score  out  SCORE_W  current score
lives  out  LIVES_W  remaining lives

Behaviour:
- All outputs registered. Each output is computed from the current state and inputs, then appears on the next clk edge.
- Reset (rst==0): state=START_GAME, score=0, lives=LIVES, all strobes 0, game_won=game_lost=0, timer_start=0. Reset mid-round aborts immediately; there is no pending-pulse carry-over.
- States: START_GAME, START_ROUND, AIM, SHOOT, END_ROUND, LIFE_LOST, END_GAME.
- START_GAME: clear score, set lives=LIVES, clear won/lost -> START_ROUND.
- START_ROUND: all target_write_xy, target_write_dxy, and shot_write_xy bits = 1 (one cycle) -> AIM.
- AIM: all target_enable_update=1. Priority: ship_collision -> LIFE_LOST; else launch_key -> SHOOT.
- SHOOT: all shot_write_dxy=1 in the first SHOOT cycle only. All target and shot enable_update=1. Priority, highest first:
  1. ship_collision -> LIFE_LOST
  2. |shot_hit -> score+1, saturating at 2^SCORE_W-1 -> END_ROUND
  3. any target off-screen, or all shots off-screen -> START_ROUND (miss, no penalty)
- Simultaneous hit and collision: the collision wins and the score is unchanged.
- END_ROUND: score ≥ WIN_SCORE -> END_GAME with game_won=1 and timer_start pulse; else START_ROUND.
- LIFE_LOST: lives-1 (never below 0). If the new value is 0 -> END_GAME with game_lost=1 and timer_start pulse; else START_ROUND.
- END_GAME: all strobes 0. end_of_game_timer_running is ignored in the first END_GAME cycle, which covers the timer-start latency. Afterwards, running==0 -> START_GAME.
- end_of_game_timer_start is exactly one cycle wide per game end. game_won and game_lost are never both 1.
- Holding launch_key across START_ROUND/AIM re-fires on entry to AIM. This is intended auto-fire.

Decomposition:
- Package game_master_pkg:
  - state enum (3-bit)
  - helper function any_off(vec) = ~&vec
  - default-parameter localparams
- One sub-module, game_score_lives: saturating score increment, lives decrement, and clear/load on START_GAME. Both counters use the same synchronous active-low reset.

Test Plan:
(N_TARGETS=3, N_SHOTS=2, WIN_SCORE=2, LIVES=2, all within_screen=1 unless stated)
1. Reset release, then idle -> START_ROUND at cycle 1. target_write_xy=3'b111 and shot_write_xy=2'b11 for exactly one cycle; score=0, lives=2.
2. launch_key for one cycle in AIM -> shot_write_dxy=2'b11 for one cycle. shot_hit=3'b010 -> score=1, new round starts. A second hit -> score=2, game_won=1, one-cycle timer_start.
3. SHOOT with shot_within_screen 2'b11->2'b00 and no hit -> START_ROUND; score and lives unchanged.
4. ship_collision in AIM, twice across rounds -> lives 2->1->0, then game_lost=1 and one timer_start pulse.
5. shot_hit=3'b001 and ship_collision in the same cycle -> lives decrements, score stays.
6. In END_GAME hold running=1 for 20 cycles, then drop it -> START_GAME follows; won/lost clear, score=0, lives=2. Assert rst=0 mid-SHOOT -> all outputs at reset values at the next edge.

Source files
------------

// File: rtl/game_master_pkg.sv
// Shared types and helpers for the sprite-game master controller.
// State encoding, default sizes and the off-screen test live here.
package game_master_pkg;

  typedef enum logic [2:0] {
    S_START_GAME,
    S_START_ROUND,
    S_AIM,
    S_SHOOT,
    S_END_ROUND,
    S_LIFE_LOST,
    S_END_GAME
  } state_e;

  localparam int unsigned DEF_N_TARGETS = 3;
  localparam int unsigned DEF_N_SHOTS   = 2;
  localparam int unsigned DEF_SCORE_W   = 4;
  localparam int unsigned DEF_WIN_SCORE = 10;
  localparam int unsigned DEF_LIVES     = 3;
  localparam int unsigned DEF_LIVES_W   = 2;

  // Unused upper bits must be padded with ones by the caller.
  function automatic logic any_off(input logic [7:0] v);
    return ~&v;
  endfunction

endpackage

// File: rtl/game_score_lives.sv
// Score and lives counters: saturating increment, floored decrement,
// reload on game start.
module game_score_lives #(
  parameter int unsigned SCORE_W = 4,
  parameter int unsigned LIVES_W = 2,
  parameter int unsigned LIVES   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [SCORE_W-1:0] score_o,
  output logic [LIVES_W-1:0] lives_o
);

  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIVES_W-1:0] lives_q, lives_d;

  always_comb begin
    score_d = score_q;
    lives_d = lives_q;
    if (clear_i) begin
      score_d = '0;
      lives_d = LIVES_W'(LIVES);
    end else begin
      if (inc_i && (score_q != '1))
        score_d = score_q + SCORE_W'(1);
      if (dec_i && (lives_q != '0))
        lives_d = lives_q - LIVES_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      score_q <= '0;
      lives_q <= LIVES_W'(LIVES);
    end else begin
      score_q <= score_d;
      lives_q <= lives_d;
    end
  end

  assign score_o = score_q;
  assign lives_o = lives_q;

endmodule

// File: rtl/game_master_fsm_param.sv
// Round sequencer for the sprite shooting game: drives per-sprite
// strobes and reports win/loss to the end-of-game timer.
module game_master_fsm_param
  import game_master_pkg::*;
#(
  parameter int unsigned N_TARGETS = DEF_N_TARGETS,
  parameter int unsigned N_SHOTS   = DEF_N_SHOTS,
  parameter int unsigned SCORE_W   = DEF_SCORE_W,
  parameter int unsigned WIN_SCORE = DEF_WIN_SCORE,
  parameter int unsigned LIVES     = DEF_LIVES,
  parameter int unsigned LIVES_W   = DEF_LIVES_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 launch_key,
  input  logic [N_TARGETS-1:0] target_within_screen,
  input  logic [N_SHOTS-1:0]   shot_within_screen,
  input  logic [N_TARGETS-1:0] shot_hit,
  input  logic                 ship_collision,
  input  logic                 end_of_game_timer_running,
  output logic [N_TARGETS-1:0] target_write_xy,
  output logic [N_TARGETS-1:0] target_write_dxy,
  output logic [N_TARGETS-1:0] target_enable_update,
  output logic [N_SHOTS-1:0]   shot_write_xy,
  output logic [N_SHOTS-1:0]   shot_write_dxy,
  output logic [N_SHOTS-1:0]   shot_enable_update,
  output logic                 end_of_game_timer_start,
  output logic                 game_won,
  output logic                 game_lost,
  output logic [SCORE_W-1:0]   score,
  output logic [LIVES_W-1:0]   lives
);

  state_e state_q, state_d;
  state_e prev_q;

  logic [N_TARGETS-1:0] txy_q, txy_d;
  logic [N_TARGETS-1:0] tdxy_q, tdxy_d;
  logic [N_TARGETS-1:0] ten_q, ten_d;
  logic [N_SHOTS-1:0]   sxy_q, sxy_d;
  logic [N_SHOTS-1:0]   sdxy_q, sdxy_d;
  logic [N_SHOTS-1:0]   sen_q, sen_d;
  logic                 start_q, start_d;
  logic                 won_q, won_d;
  logic                 lost_q, lost_d;

  logic       clr, inc, dec;
  logic [7:0] tws_pad;
  logic       miss;

  always_comb begin
    tws_pad = '1;
    tws_pad[N_TARGETS-1:0] = target_within_screen;
  end

  assign miss = any_off(tws_pad) || ~|shot_within_screen;

  always_comb begin
    state_d = state_q;
    txy_d   = '0;
    tdxy_d  = '0;
    ten_d   = '0;
    sxy_d   = '0;
    sdxy_d  = '0;
    sen_d   = '0;
    start_d = 1'b0;
    won_d   = won_q;
    lost_d  = lost_q;
    clr     = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      S_START_GAME: begin
        clr     = 1'b1;
        won_d   = 1'b0;
        lost_d  = 1'b0;
        state_d = S_START_ROUND;
      end
      S_START_ROUND: begin
        txy_d   = '1;
        tdxy_d  = '1;
        sxy_d   = '1;
        state_d = S_AIM;
      end
      S_AIM: begin
        ten_d = '1;
        if (ship_collision)
          state_d = S_LIFE_LOST;
        else if (launch_key)
          state_d = S_SHOOT;
      end
      S_SHOOT: begin
        ten_d = '1;
        sen_d = '1;
        if (prev_q != S_SHOOT)
          sdxy_d = '1;
        // Collision outranks a same-cycle hit.
        if (ship_collision) begin
          state_d = S_LIFE_LOST;
        end else if (|shot_hit) begin
          inc     = 1'b1;
          state_d = S_END_ROUND;
        end else if (miss) begin
          state_d = S_START_ROUND;
        end
      end
      S_END_ROUND: begin
        if (score >= SCORE_W'(WIN_SCORE)) begin
          won_d   = 1'b1;
          start_d = 1'b1;
          state_d = S_END_GAME;
        end else begin
          state_d = S_START_ROUND;
        end
      end
      S_LIFE_LOST: begin
        dec = 1'b1;
        if (lives <= LIVES_W'(1)) begin
          lost_d  = 1'b1;
          start_d = 1'b1;
          state_d = S_END_GAME;
        end else begin
          state_d = S_START_ROUND;
        end
      end
      S_END_GAME: begin
        // First cycle covers the timer's start latency.
        if ((prev_q == S_END_GAME) && !end_of_game_timer_running)
          state_d = S_START_GAME;
      end
      default: state_d = S_START_GAME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_START_GAME;
      prev_q  <= S_START_GAME;
      txy_q   <= '0;
      tdxy_q  <= '0;
      ten_q   <= '0;
      sxy_q   <= '0;
      sdxy_q  <= '0;
      sen_q   <= '0;
      start_q <= 1'b0;
      won_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= state_q;
      txy_q   <= txy_d;
      tdxy_q  <= tdxy_d;
      ten_q   <= ten_d;
      sxy_q   <= sxy_d;
      sdxy_q  <= sdxy_d;
      sen_q   <= sen_d;
      start_q <= start_d;
      won_q   <= won_d;
      lost_q  <= lost_d;
    end
  end

  game_score_lives #(
    .SCORE_W (SCORE_W),
    .LIVES_W (LIVES_W),
    .LIVES   (LIVES)
  ) u_sl (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clr),
    .inc_i   (inc),
    .dec_i   (dec),
    .score_o (score),
    .lives_o (lives)
  );

  assign target_write_xy         = txy_q;
  assign target_write_dxy        = tdxy_q;
  assign target_enable_update    = ten_q;
  assign shot_write_xy           = sxy_q;
  assign shot_write_dxy          = sdxy_q;
  assign shot_enable_update      = sen_q;
  assign end_of_game_timer_start = start_q;
  assign game_won                = won_q;
  assign game_lost               = lost_q;

endmodule

// File: tb/tb_game_master_fsm_param.sv
// Directed bench for game_master_fsm_param with a rule-level model
// checked every cycle plus hand-computed literal expectations.
module tb_game_master_fsm_param;

  localparam int NT   = 3;
  localparam int NS   = 2;
  localparam int WIN  = 2;
  localparam int LV0  = 2;
  localparam int SMAX = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          launch = 1'b0;
  logic [NT-1:0] tws = 3'b111;
  logic [NS-1:0] sws = 2'b11;
  logic [NT-1:0] hit = '0;
  logic          coll = 1'b0;
  logic          running = 1'b0;

  logic [NT-1:0] txy, tdxy, ten;
  logic [NS-1:0] sxy, sdxy, sen;
  logic          ts, won, lost;
  logic [3:0]    score;
  logic [1:0]    lives;

  int  nvec = 0;
  int  nerr = 0;
  bit  armed = 0;

  game_master_fsm_param #(
    .N_TARGETS (NT),
    .N_SHOTS   (NS),
    .SCORE_W   (4),
    .WIN_SCORE (WIN),
    .LIVES     (LV0),
    .LIVES_W   (2)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .launch_key                (launch),
    .target_within_screen      (tws),
    .shot_within_screen        (sws),
    .shot_hit                  (hit),
    .ship_collision            (coll),
    .end_of_game_timer_running (running),
    .target_write_xy           (txy),
    .target_write_dxy          (tdxy),
    .target_enable_update      (ten),
    .shot_write_xy             (sxy),
    .shot_write_dxy            (sdxy),
    .shot_enable_update        (sen),
    .end_of_game_timer_start   (ts),
    .game_won                  (won),
    .game_lost                 (lost),
    .score                     (score),
    .lives                     (lives)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  // Game phases of the model
  localparam int PG = 0, PR = 1, PA = 2, PS = 3;
  localparam int PE = 4, PL = 5, PX = 6;

  int ph, prevph, nph, sc, lv;
  bit m_won, m_lost, e_ts;
  logic [NT-1:0] e_txy, e_tdxy, e_ten;
  logic [NS-1:0] e_sxy, e_sdxy, e_sen;

  always @(posedge clk) begin
    e_txy = '0; e_tdxy = '0; e_ten = '0;
    e_sxy = '0; e_sdxy = '0; e_sen = '0;
    e_ts = 0;
    if (!rst) begin
      ph = PG; prevph = PG;
      sc = 0; lv = LV0;
      m_won = 0; m_lost = 0;
    end else begin
      nph = ph;
      if (ph == PG) begin
        sc = 0; lv = LV0; m_won = 0; m_lost = 0;
        nph = PR;
      end else if (ph == PR) begin
        e_txy = '1; e_tdxy = '1; e_sxy = '1;
        nph = PA;
      end else if (ph == PA) begin
        e_ten = '1;
        if (coll) nph = PL;
        else if (launch) nph = PS;
      end else if (ph == PS) begin
        e_ten = '1; e_sen = '1;
        if (prevph != PS) e_sdxy = '1;
        if (coll) nph = PL;
        else if (hit != 0) begin
          sc = (sc < SMAX) ? sc + 1 : SMAX;
          nph = PE;
        end else if (tws != 3'b111 || sws == 0)
          nph = PR;
      end else if (ph == PE) begin
        if (sc >= WIN) begin
          m_won = 1; e_ts = 1; nph = PX;
        end else nph = PR;
      end else if (ph == PL) begin
        lv = (lv > 0) ? lv - 1 : 0;
        if (lv == 0) begin
          m_lost = 1; e_ts = 1; nph = PX;
        end else nph = PR;
      end else if (ph == PX) begin
        if (prevph == PX && !running) nph = PG;
      end
      prevph = ph;
      ph = nph;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m_txy",   32'(txy),   32'(e_txy));
      chk("m_tdxy",  32'(tdxy),  32'(e_tdxy));
      chk("m_ten",   32'(ten),   32'(e_ten));
      chk("m_sxy",   32'(sxy),   32'(e_sxy));
      chk("m_sdxy",  32'(sdxy),  32'(e_sdxy));
      chk("m_sen",   32'(sen),   32'(e_sen));
      chk("m_ts",    32'(ts),    32'(e_ts));
      chk("m_won",   32'(won),   32'(m_won));
      chk("m_lost",  32'(lost),  32'(m_lost));
      chk("m_score", 32'(score), 32'(sc));
      chk("m_lives", 32'(lives), 32'(lv));
      if (won && lost) chk("won_lost_excl", 32'd1, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic fire();
    launch = 1; step(); launch = 0;
  endtask

  initial begin
    repeat (3) step();
    armed = 1;
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_lives", 32'(lives), 32'd2);
    chk("rst_txy",   32'(txy),   32'd0);
    chk("rst_ts",    32'(ts),    32'd0);
    rst = 1;
    step();
    chk("t1_txy0", 32'(txy), 32'd0);
    step();
    chk("t1_txy",  32'(txy),  32'b111);
    chk("t1_tdxy", 32'(tdxy), 32'b111);
    chk("t1_sxy",  32'(sxy),  32'b11);
    step();
    chk("t1_txy_off", 32'(txy), 32'd0);
    chk("t1_ten",     32'(ten), 32'b111);
    // hit round
    fire();
    step();
    chk("t2_sdxy", 32'(sdxy), 32'b11);
    chk("t2_sen",  32'(sen),  32'b11);
    hit = 3'b010;
    step();
    hit = 0;
    chk("t2_score1",  32'(score), 32'd1);
    chk("t2_sdxy_off", 32'(sdxy), 32'd0);
    step(); step();
    chk("t2_newround", 32'(txy), 32'b111);
    // miss round
    fire();
    sws = 2'b00;
    step();
    sws = 2'b11;
    chk("t3_score", 32'(score), 32'd1);
    chk("t3_lives", 32'(lives), 32'd2);
    step();
    chk("t3_newround", 32'(sxy), 32'b11);
    // simultaneous hit and collision
    fire();
    hit = 3'b001; coll = 1;
    step();
    hit = 0; coll = 0;
    chk("t5_score", 32'(score), 32'd1);
    step();
    chk("t5_lives", 32'(lives), 32'd1);
    chk("t5_lost",  32'(lost),  32'd0);
    step();
    // winning hit
    running = 1;
    fire();
    hit = 3'b010;
    step();
    hit = 0;
    chk("t2_score2", 32'(score), 32'd2);
    chk("t2_won0",   32'(won),   32'd0);
    step();
    chk("t2_won",  32'(won),  32'd1);
    chk("t2_ts",   32'(ts),   32'd1);
    chk("t2_lost", 32'(lost), 32'd0);
    step();
    chk("t2_ts_off", 32'(ts), 32'd0);
    repeat (19) step();
    chk("t6_hold_won", 32'(won), 32'd1);
    running = 0;
    step();
    step();
    chk("t6_won_clr", 32'(won),   32'd0);
    chk("t6_score0",  32'(score), 32'd0);
    chk("t6_lives2",  32'(lives), 32'd2);
    step();
    // two collisions in AIM
    coll = 1; step(); coll = 0;
    step();
    chk("t4_lives1", 32'(lives), 32'd1);
    step();
    coll = 1; step(); coll = 0;
    step();
    chk("t4_lives0", 32'(lives), 32'd0);
    chk("t4_lost",   32'(lost),  32'd1);
    chk("t4_won",    32'(won),   32'd0);
    chk("t4_ts",     32'(ts),    32'd1);
    step();
    chk("t4_ts_off", 32'(ts), 32'd0);
    step(); step();
    chk("t6_lost_clr", 32'(lost),  32'd0);
    chk("t6_lives_rl", 32'(lives), 32'd2);
    step();
    // reset mid-SHOOT
    fire();
    step();
    chk("t6_in_shoot", 32'(sen), 32'b11);
    rst = 0;
    step();
    chk("t6_rst_sen",   32'(sen),   32'd0);
    chk("t6_rst_ten",   32'(ten),   32'd0);
    chk("t6_rst_sdxy",  32'(sdxy),  32'd0);
    chk("t6_rst_score", 32'(score), 32'd0);
    chk("t6_rst_lives", 32'(lives), 32'd2);
    rst = 1;
    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
